// File: rtl/freq_meter_pkg.sv
// Shared constants for the frequency meter: BCD digit geometry and default gate timing.
package freq_meter_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
  localparam int NUM_DIGITS = 4;

  // One-second gate at a 100 MHz system clock
  localparam int DEFAULT_GATE_CYCLES = 100_000_000;
  localparam int DEFAULT_GATE_W = 27;

endpackage

// File: rtl/freq_meter_bcd_digit_cnt.sv
// One decade (0..9) counter stage; stages are chained through carry_out.
module bcd_digit_cnt
  import freq_meter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               load,
  input  logic               clear,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry_out
);

  assign carry_out = inc && (digit == DIGIT_MAX);

  // Priority: clear, then load, then increment; loads above 9 saturate to 9
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
    end else if (clear) begin
      digit <= '0;
    end else if (load) begin
      digit <= (load_val > DIGIT_MAX) ? DIGIT_MAX : load_val;
    end else if (inc) begin
      digit <= carry_out ? '0 : digit + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over a gate of GATE_CYCLES clocks in four BCD digits.
// meas_valid is a one-cycle strobe with no back-pressure: freq_bcd/freq_ovf change only with it.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
  parameter int GATE_W      = DEFAULT_GATE_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        sig_in,
  output logic [15:0] freq_bcd,
  output logic        freq_ovf,
  output logic        meas_valid,
  output logic        gate_active
);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  logic              s1, s2, s3;
  logic              edge_det;
  logic [GATE_W-1:0] gate_cnt;
  logic              terminal;
  logic              count_raw;
  logic              ovf_acc;
  logic              dig_load;
  logic [DIGIT_W-1:0] units_load_val, upper_load_val;
  logic [DIGIT_W-1:0] d0, d1, d2, d3;
  logic              c0, c1, c2, c3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det  = s2 & ~s3;
  assign terminal  = en && (gate_cnt == GATE_LAST);
  assign count_raw = en & edge_det & ~terminal;

  // c3 fires only when 9999 would roll over; that same cycle reloads 9s to hold
  assign dig_load       = terminal | c3;
  assign units_load_val = terminal ? {{(DIGIT_W-1){1'b0}}, edge_det} : DIGIT_MAX;
  assign upper_load_val = terminal ? '0 : DIGIT_MAX;

  bcd_digit_cnt u_dig0 (.clk(clk), .rst_n(rst_n), .inc(count_raw), .load_val(units_load_val),
                        .load(dig_load), .clear(~en), .digit(d0), .carry_out(c0));
  bcd_digit_cnt u_dig1 (.clk(clk), .rst_n(rst_n), .inc(c0), .load_val(upper_load_val),
                        .load(dig_load), .clear(~en), .digit(d1), .carry_out(c1));
  bcd_digit_cnt u_dig2 (.clk(clk), .rst_n(rst_n), .inc(c1), .load_val(upper_load_val),
                        .load(dig_load), .clear(~en), .digit(d2), .carry_out(c2));
  bcd_digit_cnt u_dig3 (.clk(clk), .rst_n(rst_n), .inc(c2), .load_val(upper_load_val),
                        .load(dig_load), .clear(~en), .digit(d3), .carry_out(c3));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
      ovf_acc  <= 1'b0;
    end else if (!en || terminal) begin
      gate_cnt <= '0;
      ovf_acc  <= 1'b0;
    end else begin
      gate_cnt <= gate_cnt + GATE_W'(1);
      if (c3) begin
        ovf_acc <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_bcd    <= '0;
      freq_ovf    <= 1'b0;
      meas_valid  <= 1'b0;
      gate_active <= 1'b0;
    end else begin
      meas_valid  <= terminal;
      gate_active <= en;
      if (terminal) begin
        freq_bcd <= {d3, d2, d1, d0};
        freq_ovf <= ovf_acc;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench: a short-gate meter for timing/carry/alignment cases, a long-gate one for overflow.
module tb_freq_meter;

  logic        clk;
  logic        rst_n [2];
  logic        en    [2];
  logic        sig   [2];
  logic [15:0] bcd   [2];
  logic        ovf   [2];
  logic        mv    [2];
  logic        ga    [2];

  int n_checks;
  int n_err;

  // Per-instance stimulus generator and strobe capture state
  int          per      [2];
  int          ph       [2];
  int          tcnt     [2];
  int          vcnt     [2];
  int          last_t   [2];
  logic [15:0] last_bcd [2];
  logic        last_ovf [2];
  logic        prev_mv  [2];

  freq_meter #(.GATE_CYCLES(1000), .GATE_W(10)) dut_a (
    .clk(clk), .rst_n(rst_n[0]), .en(en[0]), .sig_in(sig[0]),
    .freq_bcd(bcd[0]), .freq_ovf(ovf[0]), .meas_valid(mv[0]), .gate_active(ga[0])
  );

  freq_meter #(.GATE_CYCLES(40011), .GATE_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n[1]), .en(en[1]), .sig_in(sig[1]),
    .freq_bcd(bcd[1]), .freq_ovf(ovf[1]), .meas_valid(mv[1]), .gate_active(ga[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int i);
    @(negedge clk);
    tcnt[i]++;
    if (per[i] != 0) begin
      ph[i]  = (ph[i] + 1 >= per[i]) ? 0 : ph[i] + 1;
      sig[i] = (ph[i] < per[i] / 2);
    end
    if (mv[i]) begin
      check("valid_width", {31'd0, prev_mv[i]}, 0);
      vcnt[i]++;
      last_t[i]   = tcnt[i];
      last_bcd[i] = bcd[i];
      last_ovf[i] = ovf[i];
    end
    prev_mv[i] = mv[i];
  endtask

  task automatic wait_strobe(input int i, input int budget, input string tag);
    int v0;
    int n;
    v0 = vcnt[i];
    n  = 0;
    while (vcnt[i] == v0 && n < budget) begin
      tick(i);
      n++;
    end
    check({tag, "_seen"}, {31'd0, vcnt[i] != v0}, 1);
  endtask

  task automatic seq_a();
    int ts;
    int tp;
    int v0;
    per[0] = 0; ph[0] = 0; sig[0] = 1'b0; en[0] = 1'b0; rst_n[0] = 1'b0;
    repeat (3) tick(0);
    check("rst_bcd", bcd[0], 16'h0000);
    check("rst_ovf", ovf[0], 0);
    check("rst_valid", mv[0], 0);
    check("rst_gate", ga[0], 0);
    rst_n[0] = 1'b1;
    tick(0);

    // Steady period-10 input: 100 edges in every full window
    per[0] = 10; ph[0] = 0; en[0] = 1'b1; ts = tcnt[0];
    wait_strobe(0, 1100, "t1_first");
    check("t1_first_time", last_t[0] - ts, 1000);
    check("t1_gate_active", ga[0], 1);
    for (int k = 0; k < 2; k++) begin
      tp = last_t[0];
      wait_strobe(0, 1100, "t1_win");
      check("t1_bcd", last_bcd[0], 16'h0100);
      check("t1_ovf", last_ovf[0], 0);
      check("t1_interval", last_t[0] - tp, 1000);
    end

    // Rising edges phased so edge_det lands in every terminal cycle
    en[0] = 1'b0; per[0] = 0; sig[0] = 1'b0;
    repeat (10) tick(0);
    check("t4_gate_off", ga[0], 0);
    ph[0] = 3; per[0] = 10; en[0] = 1'b1; ts = tcnt[0];
    wait_strobe(0, 1100, "t4_first");
    check("t4_first_time", last_t[0] - ts, 1000);
    check("t4_bcd_w1", last_bcd[0], 16'h0100);
    tp = last_t[0];
    wait_strobe(0, 1100, "t4_second");
    check("t4_bcd_w2", last_bcd[0], 16'h0100);
    check("t4_interval", last_t[0] - tp, 1000);

    // Drop enable mid-window, then restart
    repeat (500) tick(0);
    en[0] = 1'b0; v0 = vcnt[0];
    repeat (200) tick(0);
    check("t5_no_strobe", vcnt[0] - v0, 0);
    check("t5_gate_off", ga[0], 0);
    check("t5_bcd_hold", bcd[0], 16'h0100);
    en[0] = 1'b1; ts = tcnt[0];
    wait_strobe(0, 1100, "t5_restart");
    check("t5_restart_time", last_t[0] - ts, 1000);

    // Ten isolated pulses mid-window: units carry into tens
    per[0] = 0; sig[0] = 1'b0;
    wait_strobe(0, 1100, "t2_flush1");
    wait_strobe(0, 1100, "t2_flush2");
    repeat (300) tick(0);
    repeat (10) begin
      sig[0] = 1'b1;
      repeat (10) tick(0);
      sig[0] = 1'b0;
      repeat (10) tick(0);
    end
    wait_strobe(0, 1100, "t2_burst");
    check("t2_bcd_burst", last_bcd[0], 16'h0010);
    check("t2_ovf_burst", last_ovf[0], 0);
    wait_strobe(0, 1100, "t2_idle");
    check("t2_bcd_idle", last_bcd[0], 16'h0000);

    // Reset asserted at gate count 700 of a running window
    per[0] = 10; ph[0] = 0;
    wait_strobe(0, 1100, "t6_pre");
    check("t6_pre_bcd", last_bcd[0], 16'h0100);
    repeat (700) tick(0);
    rst_n[0] = 1'b0;
    #1;
    check("t6_rst_bcd", bcd[0], 16'h0000);
    check("t6_rst_ovf", ovf[0], 0);
    check("t6_rst_valid", mv[0], 0);
    check("t6_rst_gate", ga[0], 0);
    repeat (5) tick(0);
    check("t6_rst_hold", bcd[0], 16'h0000);
    rst_n[0] = 1'b1; ts = tcnt[0];
    wait_strobe(0, 1100, "t6_after");
    check("t6_after_time", last_t[0] - ts, 1000);
    check("t6_gate_active", ga[0], 1);
  endtask

  task automatic seq_b();
    int ts;
    per[1] = 0; ph[1] = 0; sig[1] = 1'b0; en[1] = 1'b0; rst_n[1] = 1'b0;
    repeat (3) tick(1);
    check("b_rst_bcd", bcd[1], 16'h0000);
    rst_n[1] = 1'b1;

    // Period 4 over a 40011-cycle gate exceeds 9999 edges
    per[1] = 4; ph[1] = 0;
    repeat (20) tick(1);
    en[1] = 1'b1; ts = tcnt[1];
    wait_strobe(1, 41000, "b_ovf_win");
    check("b_ovf_time", last_t[1] - ts, 40011);
    check("b_ovf_bcd", last_bcd[1], 16'h9999);
    check("b_ovf_flag", last_ovf[1], 1);

    // Period 10 restarted cleanly: 40010 counting slots hold exactly 4001 edges
    en[1] = 1'b0; per[1] = 10; ph[1] = 0;
    repeat (20) tick(1);
    en[1] = 1'b1; ts = tcnt[1];
    wait_strobe(1, 41000, "b_norm_win");
    check("b_norm_time", last_t[1] - ts, 40011);
    check("b_norm_bcd", last_bcd[1], 16'h4001);
    check("b_norm_ovf", last_ovf[1], 0);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    for (int i = 0; i < 2; i++) begin
      tcnt[i]     = 0;
      vcnt[i]     = 0;
      last_t[i]   = 0;
      last_bcd[i] = '0;
      last_ovf[i] = 1'b0;
      prev_mv[i]  = 1'b0;
      per[i]      = 0;
      ph[i]       = 0;
      sig[i]      = 1'b0;
      en[i]       = 1'b0;
      rst_n[i]    = 1'b0;
    end
    fork
      seq_a();
      seq_b();
    join
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
